// File: rtl/add_rr_arbiter_pkg.sv
// Shared definitions for the round-robin adder arbiter: datapath width,
// FSM state encoding and the signed-overflow helper.
package add_arb_pkg;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Signed overflow: both operands share a sign that the sum does not.
    function automatic logic add_ovf(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b,
                                     input logic [DATA_W-1:0] s);
        return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    endfunction
endpackage

// File: rtl/add_rr_arbiter_if.sv
// Requester/consumer bundle for the adder arbiter. The master side is the
// requester/consumer side; the slave side is the arbiter.
interface add_rr_arbiter_if
    import add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0][DATA_W-1:0] req_op1;
    logic [NREQ-1:0][DATA_W-1:0] req_op2;
    logic [NREQ-1:0]             req_ready;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [DATA_W-1:0]           rsp_data;
    logic                        rsp_carry;
    logic                        rsp_ovf;
    logic [IDW-1:0]              rsp_id;

    modport master (
        output req_valid, req_op1, req_op2, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_ovf, rsp_id
    );

    modport slave (
        input  req_valid, req_op1, req_op2, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_ovf, rsp_id
    );
endinterface

// File: rtl/add_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: search starts one past the pointer and
// wraps, returning a one-hot grant, its index and an any-request flag.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);
    int w_c;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_c   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_c = (int'(i_ptr) + k) % NREQ;
            if (!o_any && i_req[w_c]) begin
                o_any      = 1'b1;
                o_gnt[w_c] = 1'b1;
                o_idx      = IDW'(w_c);
            end
        end
    end
endmodule

// File: rtl/add_rr_arbiter.sv
// Time-shares the single 32-bit adder among NREQ requesters: round-robin
// grant, operand register stage, registered result held until accepted.
module add_rr_arbiter
    import add_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    add_rr_arbiter_if.slave      bus,
    output logic                 busy
);
    state_t            r_state;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_id;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_carry;
    logic              r_rsp_ovf;
    logic [IDW-1:0]    r_rsp_id;
    logic              r_busy;

    logic [NREQ-1:0]   w_gnt;
    logic [IDW-1:0]    w_idx;
    logic              w_any;
    logic [DATA_W-1:0] w_sum;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // The shared adder, fed only from the operand registers.
    assign w_sum = r_op1 + r_op2;

    // Gated by rst_n so the accept strobe drops the moment reset asserts.
    assign bus.req_ready = (r_state == ST_IDLE && rst_n) ? w_gnt : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_carry = r_rsp_carry;
    assign bus.rsp_ovf   = r_rsp_ovf;
    assign bus.rsp_id    = r_rsp_id;
    assign busy          = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= IDW'(NREQ - 1);
            r_id        <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_ovf   <= 1'b0;
            r_rsp_id    <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_op1   <= bus.req_op1[w_idx];
                        r_op2   <= bus.req_op2[w_idx];
                        r_id    <= w_idx;
                        r_ptr   <= w_idx;
                        r_busy  <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_data  <= w_sum;
                    r_rsp_carry <= (w_sum < r_op1);
                    r_rsp_ovf   <= add_ovf(r_op1, r_op2, w_sum);
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    // Result fields stay as-is after the handshake.
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add_rr_arbiter.sv
// Directed bench for add_rr_arbiter: single ops with flag corners, fair
// rotation, back-pressure hold and asynchronous reset mid-operation.
module tb_add_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   n_cmp = 0;
    int   n_err = 0;

    add_rr_arbiter_if #(.NREQ(4)) bus ();

    add_rr_arbiter #(.NREQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated op from requester idx; consumer holds rsp_ready low until
    // the result is visible, then accepts it.
    task automatic do_op(input string tag, input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_sum, input logic e_c, input logic e_o);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        bus.req_valid    = oh;
        bus.req_op1[idx] = a;
        bus.req_op2[idx] = b;
        #1;
        chk({tag, ".ready"}, 64'(bus.req_ready), 64'(oh));
        step();
        bus.req_valid = '0;
        chk({tag, ".exec_busy"}, 64'(busy), 64'd1);
        chk({tag, ".exec_rv"}, 64'(bus.rsp_valid), 64'd0);
        step();
        chk({tag, ".rv"}, 64'(bus.rsp_valid), 64'd1);
        chk({tag, ".data"}, 64'(bus.rsp_data), 64'(e_sum));
        chk({tag, ".carry"}, 64'(bus.rsp_carry), 64'(e_c));
        chk({tag, ".ovf"}, 64'(bus.rsp_ovf), 64'(e_o));
        chk({tag, ".id"}, 64'(bus.rsp_id), 64'(idx));
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk({tag, ".rv_clr"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, ".busy_clr"}, 64'(busy), 64'd0);
        chk({tag, ".data_hold"}, 64'(bus.rsp_data), 64'(e_sum));
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_op1   = '0;
        bus.req_op2   = '0;
        bus.rsp_ready = 1'b0;
        #12;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.rv", 64'(bus.rsp_valid), 64'd0);
        chk("rst.data", 64'(bus.rsp_data), 64'd0);
        chk("rst.flags", 64'({bus.rsp_carry, bus.rsp_ovf}), 64'd0);
        chk("rst.id", 64'(bus.rsp_id), 64'd0);
        chk("rst.ready", 64'(bus.req_ready), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle.ready", 64'(bus.req_ready), 64'd0);

        do_op("t1", 0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);
        do_op("t2", 2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        do_op("t3", 1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        do_op("t3b", 3, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);

        // Fresh pointer so rotation begins at req0.
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            bus.req_op1[i] = 32'h1000_0000 * (i + 1);
            bus.req_op2[i] = 32'h11 * (i + 1);
        end
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % 4;
            #1;
            chk($sformatf("t4.grant%0d", k), 64'(bus.req_ready), 64'(4'b0001 << g));
            step();
            chk($sformatf("t4.ready_exec%0d", k), 64'(bus.req_ready), 64'd0);
            step();
            chk($sformatf("t4.rv%0d", k), 64'(bus.rsp_valid), 64'd1);
            chk($sformatf("t4.id%0d", k), 64'(bus.rsp_id), 64'(g));
            chk($sformatf("t4.data%0d", k), 64'(bus.rsp_data), 64'((32'h1000_0000 + 32'h11) * (g + 1)));
            step();
            chk($sformatf("t4.rv_clr%0d", k), 64'(bus.rsp_valid), 64'd0);
        end

        // Back-pressure: pointer now 0, only req3 asks first.
        bus.rsp_ready  = 1'b0;
        bus.req_valid  = 4'b1000;
        bus.req_op1[3] = 32'hDEAD_BEEF;
        bus.req_op2[3] = 32'h0000_0001;
        #1;
        chk("t5.grant3", 64'(bus.req_ready), 64'b1000);
        step();
        bus.req_valid = 4'b0001;
        step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t5.rv%0d", k), 64'(bus.rsp_valid), 64'd1);
            chk($sformatf("t5.data%0d", k), 64'(bus.rsp_data), 64'hDEAD_BEF0);
            chk($sformatf("t5.id%0d", k), 64'(bus.rsp_id), 64'd3);
            chk($sformatf("t5.ready%0d", k), 64'(bus.req_ready), 64'd0);
            chk($sformatf("t5.busy%0d", k), 64'(busy), 64'd1);
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        chk("t5.rv_clr", 64'(bus.rsp_valid), 64'd0);
        chk("t5.next_grant", 64'(bus.req_ready), 64'b0001);
        step();
        chk("t5.exec_busy", 64'(busy), 64'd1);

        // Async reset while in EXEC.
        #2 rst_n = 1'b0;
        #1;
        chk("t6.busy", 64'(busy), 64'd0);
        chk("t6.rv", 64'(bus.rsp_valid), 64'd0);
        chk("t6.ready", 64'(bus.req_ready), 64'd0);
        chk("t6.data", 64'(bus.rsp_data), 64'd0);
        #1 rst_n = 1'b1;
        bus.req_valid = 4'b0011;
        #1;
        chk("t6.grant0", 64'(bus.req_ready), 64'b0001);
        step();
        bus.req_valid = 4'b0010;
        step();
        step();
        #1;
        chk("t6.grant1", 64'(bus.req_ready), 64'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
